// File: rtl/calc_sequencer_if.sv
// Command and response handshake bundle between a requester and calc_sequencer.
// The requester drives the master side and the sequencer sits on the slave side.
interface calc_sequencer_if;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [2:0] cmd_op;
    logic [7:0] cmd_data;
    logic       rsp_valid;
    logic       rsp_ready;
    logic [7:0] rsp_data;
    logic       rsp_err;

    modport master (
        output cmd_valid, cmd_op, cmd_data, rsp_ready,
        input  cmd_ready, rsp_valid, rsp_data, rsp_err
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_data, rsp_ready,
        output cmd_ready, rsp_valid, rsp_data, rsp_err
    );
endinterface

// File: rtl/calc_sequencer.sv
// Sequences an external 8-bit calculator from a queued command stream, keeping a
// running accumulator on calculator input A and returning one response per command.
module calc_sequencer #(
    parameter int FIFO_DEPTH = 4,
    parameter int FIFO_AW    = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    calc_sequencer_if.slave        bus,
    output logic [7:0]             calc_a,
    output logic [7:0]             calc_b,
    output logic [2:0]             calc_codigo,
    input  logic [7:0]             calc_saida,
    output logic [7:0]             acc,
    output logic                   busy
);

    localparam logic [2:0] OP_CLR  = 3'b000;
    localparam logic [2:0] OP_LOAD = 3'b001;
    localparam logic [2:0] OP_ADD  = 3'b010;
    localparam logic [2:0] OP_SUB  = 3'b011;
    localparam logic [2:0] OP_READ = 3'b100;

    localparam logic [FIFO_AW-1:0] PTR_ONE  = FIFO_AW'(1'b1);
    localparam logic [FIFO_AW:0]   CNT_ONE  = (FIFO_AW+1)'(1'b1);
    localparam logic [FIFO_AW:0]   CNT_FULL = (FIFO_AW+1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t              state_r;
    logic [10:0]         mem_r [FIFO_DEPTH];
    logic [FIFO_AW-1:0]  wr_ptr_r;
    logic [FIFO_AW-1:0]  rd_ptr_r;
    logic [FIFO_AW:0]    count_r;
    logic [2:0]          op_r;
    logic [7:0]          operand_r;
    logic [7:0]          acc_r;
    logic [7:0]          calc_b_r;
    logic [2:0]          calc_code_r;
    logic                rsp_valid_r;
    logic [7:0]          rsp_data_r;
    logic                rsp_err_r;

    logic                full_s;
    logic                push_s;
    logic                pop_s;
    logic [2:0]          head_op_s;
    logic [7:0]          head_data_s;

    function automatic logic [2:0] map_code(input logic [2:0] op);
        logic [2:0] code;
        case (op)
            OP_CLR:  code = 3'b000;
            OP_LOAD: code = 3'b010;
            OP_ADD:  code = 3'b011;
            OP_SUB:  code = 3'b100;
            OP_READ: code = 3'b001;
            default: code = 3'b000;
        endcase
        return code;
    endfunction

    function automatic logic op_invalid(input logic [2:0] op);
        return (op > OP_READ);
    endfunction

    function automatic logic op_writes_acc(input logic [2:0] op);
        return (op <= OP_SUB);
    endfunction

    assign full_s      = (count_r == CNT_FULL);
    assign push_s      = bus.cmd_valid && !full_s;
    assign pop_s       = (state_r == IDLE) && (count_r != {(FIFO_AW+1){1'b0}});
    assign head_op_s   = mem_r[rd_ptr_r][10:8];
    assign head_data_s = mem_r[rd_ptr_r][7:0];

    assign bus.cmd_ready = !full_s;
    assign bus.rsp_valid = rsp_valid_r;
    assign bus.rsp_data  = rsp_data_r;
    assign bus.rsp_err   = rsp_err_r;
    assign calc_a        = acc_r;
    assign calc_b        = calc_b_r;
    assign calc_codigo   = calc_code_r;
    assign acc           = acc_r;
    assign busy          = (state_r != IDLE) || (count_r != {(FIFO_AW+1){1'b0}});

    // Command storage; contents need no reset because occupancy gates every read.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_r[wr_ptr_r] <= {bus.cmd_op, bus.cmd_data};
        end
    end

    // FIFO pointers and occupancy; the counter separates full from empty.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_r <= {FIFO_AW{1'b0}};
            rd_ptr_r <= {FIFO_AW{1'b0}};
            count_r  <= {(FIFO_AW+1){1'b0}};
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CNT_ONE;
                2'b01:   count_r <= count_r - CNT_ONE;
                default: count_r <= count_r;
            endcase
        end
    end

    // Control FSM with registered calculator drive, accumulator and response.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= IDLE;
            op_r        <= 3'b000;
            operand_r   <= 8'h00;
            acc_r       <= 8'h00;
            calc_b_r    <= 8'h00;
            calc_code_r <= 3'b000;
            rsp_valid_r <= 1'b0;
            rsp_data_r  <= 8'h00;
            rsp_err_r   <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (pop_s) begin
                        op_r        <= head_op_s;
                        operand_r   <= head_data_s;
                        calc_b_r    <= head_data_s;
                        calc_code_r <= map_code(head_op_s);
                        state_r     <= EXEC;
                    end else begin
                        state_r     <= IDLE;
                    end
                end
                EXEC: begin
                    // The calculator sees the operand for this single cycle only.
                    calc_b_r    <= 8'h00;
                    calc_code_r <= 3'b000;
                    rsp_valid_r <= 1'b1;
                    rsp_err_r   <= op_invalid(op_r);
                    rsp_data_r  <= op_invalid(op_r) ? 8'h00 : calc_saida;
                    if (op_writes_acc(op_r)) begin
                        acc_r <= calc_saida;
                    end else begin
                        acc_r <= acc_r;
                    end
                    state_r     <= RESP;
                end
                RESP: begin
                    if (bus.rsp_ready) begin
                        rsp_valid_r <= 1'b0;
                        state_r     <= IDLE;
                    end else begin
                        state_r     <= RESP;
                    end
                end
                default: begin
                    calc_b_r    <= 8'h00;
                    calc_code_r <= 3'b000;
                    rsp_valid_r <= 1'b0;
                    state_r     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/calc_sequencer.md
Name: calc_sequencer

Overview:
Command-driven controller that sequences the 8-bit calculator datapath (zero / show A / show B / add / subtract, selected by a 3-bit code).
- Accepts operation commands from a requester through a valid/ready interface and buffers them in a small FIFO.
- Keeps a running accumulator fed back into calculator input A, and drives calculator input B and the operation code.
- Returns one response per command through a valid/ready handshake.

Parameters:
FIFO_DEPTH, 4, command FIFO entries (power of two, >=2)
FIFO_AW, 2, FIFO pointer width = log2(FIFO_DEPTH)

Ports:
clk  input  1  single system clock, rising edge
rst  input  1  asynchronous, active-high reset
cmd_valid  input  1  command present
cmd_ready  output  1  FIFO can accept (= not full)
cmd_op  input  3  command opcode
cmd_data  input  8  command operand
rsp_valid  output  1  response available
rsp_ready  input  1  requester accepts response
rsp_data  output  8  calculator result captured for the command
rsp_err  output  1  command opcode was invalid
calc_a  output  8  to calculator entrada_A
calc_b  output  8  to calculator entrada_B
calc_codigo  output  3  to calculator codigo
calc_saida  input  8  from calculator saida (combinational)
acc  output  8  current accumulator value
busy  output  1  state != IDLE or FIFO not empty

Behaviour:
- Clock and reset: one clock (clk). Reset (rst) is asynchronous and active-high.
- Reset values: acc=0, rsp_valid=0, rsp_data=0, rsp_err=0, FIFO empty (cmd_ready=1), state=IDLE, op/operand registers=0, busy=0.
- Reset mid-operation clears everything above: queued commands are discarded and any pending response is dropped.

Opcode map (cmd_op -> calc_codigo, acc update):
- 000 CLR: codigo 000; acc <= 0.
- 001 LOAD: codigo 010 (show B); acc <= cmd_data.
- 010 ADD: codigo 011; acc <= (acc + data) mod 256.
- 011 SUB: codigo 100; acc <= (acc - data) mod 256.
- 100 READ: codigo 001 (show A); acc unchanged; reports acc.
- 101, 110, 111 are invalid: codigo 000, acc unchanged, rsp_data=0, rsp_err=1.

Calculator interface:
- calc_a = acc at all times.
- calc_b = latched operand and calc_codigo = mapped code, only in EXEC.
- Outside EXEC: calc_b=0, calc_codigo=000.
- All arithmetic happens in the calculator. The sequencer only latches calc_saida; no carry or overflow is reported.

FIFO:
- Push on cmd_valid && cmd_ready. cmd_ready = !full.
- A push is refused when full, even if a pop occurs in the same cycle.
- Pointers wrap modulo FIFO_DEPTH. An occupancy counter distinguishes full from empty.
- Simultaneous push and pop on a non-full, non-empty FIFO leaves occupancy unchanged.

State machine:
- IDLE: if FIFO not empty, pop head into op/operand registers -> EXEC; else stay.
- EXEC (exactly 1 cycle): drive calculator; at the clock edge:
  - rsp_data <= calc_saida (0 if invalid)
  - rsp_err <= invalid
  - acc <= calc_saida for CLR/LOAD/ADD/SUB
  - next state -> RESP
- RESP: rsp_valid=1 and rsp_data/rsp_err held stable. On rsp_ready -> IDLE (rsp_valid drops the next cycle).
  - New commands may still be pushed while in RESP.
  - Exactly one response per command, in FIFO order.
- Latency: a command pushed at edge E0 into an empty FIFO while IDLE gives rsp_valid high after edge E2.
- Throughput: one command per 3 cycles when rsp_ready is held high.
- The accumulator is only modified in EXEC. Back-to-back commands see the acc left by the previous command.

Test Plan:
- Reset then LOAD 0x05, ADD 0x03 with rsp_ready=1 -> responses 0x05, 0x08; acc=0x08; first rsp_valid 2 edges after push.
- LOAD 0x02, SUB 0x05 -> rsp 0xFD; then ADD 0x04 -> rsp 0x01 (mod-256 wrap both directions).
- Invalid op 110 after LOAD 0x77 -> rsp_err=1, rsp_data=0x00, acc stays 0x77; next READ -> 0x77, rsp_err=0.
- rsp_ready=0 and 5 commands pushed: one enters EXEC, then 4 fill the FIFO so cmd_ready=0 and the 6th is held. Release rsp_ready -> responses in push order, none lost or duplicated.
- Probe calc_codigo/calc_b per opcode during EXEC (CLR->000, LOAD->010, ADD->011, SUB->100, READ->001) and verify 000/0 outside EXEC.
- Assert rst asynchronously during RESP with 3 queued commands -> immediate rsp_valid=0, acc=0, cmd_ready=1, busy=0; no stale response after release.
